pe_pipelined: RTL and testbench

Parametrised successor to the mesh PE. It adds the following over the fixed-function element:
- a valid/ready streaming interface;
- a multi-entry stationary weight bank for systolic FMA;
- an accumulate mode and a ReLU mode;
- a configurable-depth result pipeline.

It sits at each mesh node between the switch and the library floating-point units (fadd, fmul, FMA; combinational, IEEE-754 single precision, FMA = x*y+z).

---
 rtl/pe_pipelined.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_pe_pipelined.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_pipelined.sv
// pe_pipelined: mesh processing element with a valid/ready stream interface,
// a stationary weight bank for systolic FMA, accumulate and ReLU modes, and a
// PIPE-deep result pipeline. The floating-point datapath is one fused
// multiply-add (IEEE-754 single precision, round-to-nearest-even); ADD and MUL
// are FMA with a fixed operand.
//
// Ports:
//   clk, reset              rising-edge clock, asynchronous active-high reset
//   load_cfg, load_op       latch operation code (also clears wptr and acc)
//   load_wen, load_addr,
//   load_data               weight bank write port
//   in_valid, in_ready      operand handshake; a, b, c operands
//   out_valid, out_ready    result handshake; out_data result
//   busy                    any pipeline stage holds a valid beat
module pe_pipelined #(
    parameter int unsigned W_DEPTH = 4,
    parameter int unsigned PIPE    = 2,
    localparam int unsigned ADDR_W = (W_DEPTH > 1) ? $clog2(W_DEPTH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_cfg,
    input  logic [2:0]        load_op,
    input  logic              load_wen,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       a,
    input  logic [31:0]       b,
    input  logic [31:0]       c,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic              busy
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_MUL  = 3'b001;
    localparam logic [2:0] OP_FMA  = 3'b010;
    localparam logic [2:0] OP_SYS  = 3'b011;
    localparam logic [2:0] OP_ACC  = 3'b100;
    localparam logic [2:0] OP_RELU = 3'b101;

    localparam logic [31:0] FP_ONE   = 32'h3F80_0000;
    localparam logic [31:0] FP_NZERO = 32'h8000_0000;
    localparam logic [31:0] FP_QNAN  = 32'h7FC0_0000;

    // Alignment window: bit 75 holds the top bit of the larger addend, bit 76
    // absorbs the carry of an addition.
    localparam int unsigned FW = 77;

    // Logical right shift that folds every shifted-out one into bit 0.
    function automatic logic [FW-1:0] shr_sticky(input logic [FW-1:0] v,
                                                 input int unsigned sh);
        logic [FW-1:0] r;
        logic [FW-1:0] mask;
        if (sh >= FW) begin
            r    = '0;
            r[0] = |v;
        end else begin
            mask = (FW'(1) << sh) - FW'(1);
            r    = v >> sh;
            r[0] = r[0] | (|(v & mask));
        end
        return r;
    endfunction

    function automatic int unsigned lzc(input logic [FW-1:0] v);
        int unsigned n;
        n = FW;
        for (int unsigned i = 0; i < FW; i++) begin
            if (v[i]) n = FW - 1 - i;
        end
        return n;
    endfunction

    // x*y+z with a single rounding.
    function automatic logic [31:0] fma32(input logic [31:0] x,
                                          input logic [31:0] y,
                                          input logic [31:0] z);
        logic          xs, ys, zs, ps, rs;
        logic [7:0]    xe, ye, ze, xe_eff, ye_eff, ze_eff;
        logic [22:0]   xm, ym, zm;
        logic          x_nan, y_nan, z_nan, x_inf, y_inf, z_inf;
        logic          x_zero, y_zero, z_zero;
        logic [23:0]   xsig, ysig, zsig;
        logic [47:0]   prod;
        logic [FW-1:0] fp, fz, mag, nrm;
        logic          g, st, rnd;
        logic [30:0]   body;
        logic [31:0]   res;
        int            tp, tz, big, e;
        int unsigned   lz;

        {xs, xe, xm} = x;
        {ys, ye, ym} = y;
        {zs, ze, zm} = z;
        x_nan  = (xe == 8'hFF) && (xm != 23'h0);
        y_nan  = (ye == 8'hFF) && (ym != 23'h0);
        z_nan  = (ze == 8'hFF) && (zm != 23'h0);
        x_inf  = (xe == 8'hFF) && (xm == 23'h0);
        y_inf  = (ye == 8'hFF) && (ym == 23'h0);
        z_inf  = (ze == 8'hFF) && (zm == 23'h0);
        x_zero = (xe == 8'h00) && (xm == 23'h0);
        y_zero = (ye == 8'h00) && (ym == 23'h0);
        z_zero = (ze == 8'h00) && (zm == 23'h0);
        ps     = xs ^ ys;
        // Subnormals use exponent 1 with no hidden bit.
        xe_eff = (xe == 8'h00) ? 8'd1 : xe;
        ye_eff = (ye == 8'h00) ? 8'd1 : ye;
        ze_eff = (ze == 8'h00) ? 8'd1 : ze;
        xsig   = {xe != 8'h00, xm};
        ysig   = {ye != 8'h00, ym};
        zsig   = {ze != 8'h00, zm};
        prod   = 48'(xsig) * 48'(ysig);

        res  = 32'h0;
        fp   = '0;
        fz   = '0;
        mag  = '0;
        nrm  = '0;
        rs   = 1'b0;
        g    = 1'b0;
        st   = 1'b0;
        rnd  = 1'b0;
        body = '0;
        tp   = 0;
        tz   = 0;
        big  = 0;
        e    = 0;
        lz   = 0;

        if (x_nan || y_nan || z_nan) begin
            res = FP_QNAN;
        end else if (x_inf || y_inf) begin
            if (x_zero || y_zero)         res = FP_QNAN;
            else if (z_inf && (zs != ps)) res = FP_QNAN;
            else                          res = {ps, 8'hFF, 23'h0};
        end else if (z_inf) begin
            res = z;
        end else if (x_zero || y_zero) begin
            // Exact zero product: sum of zeros is -0 only if both are -0.
            res = z_zero ? {ps & zs, 31'h0} : z;
        end else begin
            // Unbiased weight of product bit 47 and of z hidden bit.
            tp = int'(xe_eff) + int'(ye_eff) - 253;
            tz = int'(ze_eff) - 127;
            fp = {1'b0, prod, 28'h0};
            fz = {1'b0, zsig, 52'h0};
            big = (z_zero || (tp > tz)) ? tp : tz;
            fp = shr_sticky(fp, unsigned'(big - tp));
            if (!z_zero) fz = shr_sticky(fz, unsigned'(big - tz));

            if (ps == zs) begin
                mag = fp + fz;
                rs  = ps;
            end else if (fp >= fz) begin
                mag = fp - fz;
                rs  = ps;
            end else begin
                mag = fz - fp;
                rs  = zs;
            end

            if (mag == '0) begin
                res = 32'h0;
            end else begin
                lz  = lzc(mag);
                e   = big + 128 - int'(lz);
                nrm = mag << lz;
                if (e >= 255) begin
                    res = {rs, 8'hFF, 23'h0};
                end else begin
                    if (e < 1) begin
                        nrm = shr_sticky(nrm, unsigned'(1 - e));
                        e   = 0;
                    end
                    g    = nrm[52];
                    st   = |nrm[51:0];
                    rnd  = g & (st | nrm[53]);
                    // Rounding carry ripples into the exponent field, which
                    // also covers subnormal->normal and overflow to infinity.
                    body = {8'(e), nrm[75:53]} + 31'(rnd);
                    res  = {rs, body};
                end
            end
        end
        return res;
    endfunction

    logic [2:0]        cfg;
    logic [31:0]       wbank [W_DEPTH];
    logic [ADDR_W-1:0] wptr;
    logic [31:0]       acc;
    logic [PIPE-1:0]   vld;
    logic [PIPE-1:0]   vld_nxt;
    logic [31:0]       dat [PIPE];
    logic              stall;
    logic              accept;
    logic [31:0]       fx, fy, fz;
    logic [31:0]       fma_res;
    logic [31:0]       result;

    assign stall     = out_valid && !out_ready;
    assign in_ready  = !stall && !load_cfg && !load_wen;
    assign accept    = in_valid && in_ready;
    assign out_valid = vld[PIPE-1];
    assign out_data  = dat[PIPE-1];

    // Operand routing into the shared FMA.
    always_comb begin : operand_sel
        fx = a;
        fy = FP_ONE;
        fz = b;
        case (cfg)
            OP_MUL: begin
                fy = b;
                fz = FP_NZERO;
            end
            OP_FMA: begin
                fy = b;
                fz = c;
            end
            OP_SYS: begin
                fy = wbank[wptr];
                fz = b;
            end
            OP_ACC: begin
                fy = b;
                fz = acc;
            end
            default: ;
        endcase
    end

    assign fma_res = fma32(fx, fy, fz);

    always_comb begin : result_sel
        result = fma_res;
        case (cfg)
            OP_RELU: result = a[31] ? 32'h0 : a;
            3'b110,
            3'b111:  result = 32'h0;
            default: ;
        endcase
    end

    // Configuration, weight pointer and accumulator.
    always_ff @(posedge clk or posedge reset) begin : ctrl_regs
        if (reset) begin
            cfg  <= OP_ADD;
            wptr <= '0;
            acc  <= '0;
        end else if (load_cfg) begin
            cfg  <= load_op;
            wptr <= '0;
            acc  <= '0;
        end else if (accept) begin
            if (cfg == OP_SYS) begin
                wptr <= (32'(wptr) == W_DEPTH - 1) ? '0 : wptr + ADDR_W'(1);
            end
            if (cfg == OP_ACC) acc <= fma_res;
        end
    end

    // Weight bank; addresses beyond the bank are dropped.
    always_ff @(posedge clk or posedge reset) begin : weight_bank
        if (reset) begin
            for (int unsigned i = 0; i < W_DEPTH; i++) wbank[i] <= '0;
        end else if (load_wen && (32'(load_addr) < W_DEPTH)) begin
            wbank[load_addr] <= load_data;
        end
    end

    // Stage valids advance together unless the output is stalled.
    always_comb begin : valid_next
        vld_nxt = vld;
        if (!stall) begin
            vld_nxt[0] = accept;
            for (int unsigned i = 1; i < PIPE; i++) vld_nxt[i] = vld[i-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin : pipe_regs
        if (reset) begin
            vld  <= '0;
            busy <= 1'b0;
            for (int unsigned i = 0; i < PIPE; i++) dat[i] <= '0;
        end else begin
            vld  <= vld_nxt;
            busy <= |vld_nxt;
            if (!stall) begin
                if (accept) dat[0] <= result;
                for (int unsigned i = 1; i < PIPE; i++) dat[i] <= dat[i-1];
            end
        end
    end

endmodule

// File: tb/tb_pe_pipelined.sv
// Directed bench for pe_pipelined (W_DEPTH=4, PIPE=2): reset state, ADD
// latency, FMA throughput, SYS_FMA weight wrap, backpressure, ACC reload,
// ReLU/reserved ops and reset with beats in flight.
module tb_pe_pipelined;

    localparam int unsigned W_DEPTH = 4;
    localparam int unsigned PIPE    = 2;
    localparam int unsigned ADDR_W  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              load_cfg;
    logic [2:0]        load_op;
    logic              load_wen;
    logic [ADDR_W-1:0] load_addr;
    logic [31:0]       load_data;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       a, b, c;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_data;
    logic              busy;

    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;
    logic [31:0] rq [$];
    int unsigned rc [$];

    pe_pipelined #(.W_DEPTH(W_DEPTH), .PIPE(PIPE)) dut (
        .clk       (clk),
        .reset     (reset),
        .load_cfg  (load_cfg),
        .load_op   (load_op),
        .load_wen  (load_wen),
        .load_addr (load_addr),
        .load_data (load_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every completed output handshake with its cycle number.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            rq.push_back(out_data);
            rc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_config(input logic [2:0] op);
        load_cfg = 1'b1;
        load_op  = op;
        tick();
        load_cfg = 1'b0;
    endtask

    task automatic write_w(input logic [ADDR_W-1:0] addr, input logic [31:0] data);
        load_wen  = 1'b1;
        load_addr = addr;
        load_data = data;
        tick();
        load_wen  = 1'b0;
    endtask

    // Present one beat and hold it until the handshake completes.
    task automatic send(input logic [31:0] va, input logic [31:0] vb, input logic [31:0] vc);
        bit done = 0;
        in_valid = 1'b1;
        a = va;
        b = vb;
        c = vc;
        for (int k = 0; k < 30 && !done; k++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) check("send_timeout", 32'(done), 32'd1);
    endtask

    // Wait for n results, idle a little longer, then require exactly n.
    task automatic wait_results(input string tag, input int n);
        for (int k = 0; k < 40 && rq.size() < n; k++) tick();
        repeat (4) tick();
        check({tag, "_count"}, 32'(rq.size()), 32'(n));
    endtask

    task automatic expect_next(input string tag, input logic [31:0] exp);
        logic [31:0] got;
        got = (rq.size() > 0) ? rq.pop_front() : 32'hxxxx_xxxx;
        check(tag, got, exp);
    endtask

    initial begin
        logic [31:0] sys_exp [5];
        logic [31:0] hold;

        reset     = 1'b1;
        load_cfg  = 1'b0;
        load_op   = 3'b000;
        load_wen  = 1'b0;
        load_addr = '0;
        load_data = '0;
        in_valid  = 1'b0;
        a = '0;
        b = '0;
        c = '0;
        out_ready = 1'b1;
        hold      = '0;

        repeat (2) tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        reset = 1'b0;
        tick();

        // ADD latency and busy window.
        in_valid = 1'b1;
        a = 32'h3F80_0000;
        b = 32'h4000_0000;
        tick();
        in_valid = 1'b0;
        check("add_t1_busy", 32'(busy), 32'd1);
        check("add_t1_out_valid", 32'(out_valid), 32'd0);
        tick();
        check("add_t2_out_valid", 32'(out_valid), 32'd1);
        check("add_t2_out_data", out_data, 32'h4040_0000);
        check("add_t2_busy", 32'(busy), 32'd1);
        tick();
        check("add_t3_out_valid", 32'(out_valid), 32'd0);
        check("add_t3_busy", 32'(busy), 32'd0);
        rq.delete();
        rc.delete();

        // Cancellation and signed multiply.
        send(32'h3F80_0000, 32'hBF80_0000, 32'h0);
        wait_results("add_cancel", 1);
        expect_next("add_cancel", 32'h0000_0000);
        load_config(3'b001);
        send(32'h3FC0_0000, 32'hC000_0000, 32'h0);
        wait_results("mul", 1);
        expect_next("mul_neg", 32'hC040_0000);

        // FMA back-to-back throughput.
        load_config(3'b010);
        rc.delete();
        repeat (4) send(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000);
        wait_results("fma", 4);
        if (rc.size() >= 4) check("fma_consecutive", 32'(rc[3] - rc[0]), 32'd3);
        for (int i = 0; i < 4; i++) expect_next("fma_data", 32'h40A0_0000);

        // SYS_FMA weights with pointer wrap; last weight written together
        // with the config load while a beat is offered.
        write_w(2'd0, 32'h3F80_0000);
        write_w(2'd1, 32'h4000_0000);
        write_w(2'd2, 32'h4040_0000);
        load_wen  = 1'b1;
        load_addr = 2'd3;
        load_data = 32'h4080_0000;
        load_cfg  = 1'b1;
        load_op   = 3'b011;
        in_valid  = 1'b1;
        a = 32'h4100_0000;
        b = 32'h0;
        @(negedge clk);
        check("load_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        load_wen = 1'b0;
        load_cfg = 1'b0;
        in_valid = 1'b0;
        sys_exp = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h3F80_0000};
        for (int i = 0; i < 5; i++) send(32'h3F80_0000, 32'h0, 32'h0);
        wait_results("sys", 5);
        for (int i = 0; i < 5; i++) expect_next("sys_data", sys_exp[i]);

        // Backpressure: hold out_ready low for three cycles on the first result.
        load_config(3'b000);
        fork
            begin
                send(32'h3F80_0000, 32'h0, 32'h0);
                send(32'h4000_0000, 32'h0, 32'h0);
                send(32'h4040_0000, 32'h0, 32'h0);
                send(32'h4080_0000, 32'h0, 32'h0);
                send(32'h40A0_0000, 32'h0, 32'h0);
                send(32'h40C0_0000, 32'h0, 32'h0);
            end
            begin
                for (int k = 0; k < 20 && !out_valid; k++) tick();
                check("bp_first_valid", 32'(out_valid), 32'd1);
                out_ready = 1'b0;
                hold = out_data;
                check("bp_first_data", hold, 32'h3F80_0000);
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("bp_in_ready", 32'(in_ready), 32'd0);
                    check("bp_out_valid", 32'(out_valid), 32'd1);
                    check("bp_out_data_stable", out_data, hold);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_results("bp", 6);
        expect_next("bp_data0", 32'h3F80_0000);
        expect_next("bp_data1", 32'h4000_0000);
        expect_next("bp_data2", 32'h4040_0000);
        expect_next("bp_data3", 32'h4080_0000);
        expect_next("bp_data4", 32'h40A0_0000);
        expect_next("bp_data5", 32'h40C0_0000);

        // Accumulate, then reload clears acc.
        load_config(3'b100);
        repeat (3) send(32'h3F80_0000, 32'h4000_0000, 32'h0);
        wait_results("acc", 3);
        expect_next("acc_1", 32'h4000_0000);
        expect_next("acc_2", 32'h4080_0000);
        expect_next("acc_3", 32'h40C0_0000);
        load_config(3'b100);
        send(32'h3F80_0000, 32'h4000_0000, 32'h0);
        wait_results("acc_reload", 1);
        expect_next("acc_reload", 32'h4000_0000);

        // ReLU and reserved opcodes.
        load_config(3'b101);
        send(32'hC000_0000, 32'h0, 32'h0);
        send(32'h8000_0000, 32'h0, 32'h0);
        send(32'h4000_0000, 32'h0, 32'h0);
        wait_results("relu", 3);
        expect_next("relu_neg", 32'h0000_0000);
        expect_next("relu_negzero", 32'h0000_0000);
        expect_next("relu_pos", 32'h4000_0000);
        load_config(3'b110);
        send(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000);
        load_config(3'b111);
        send(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000);
        wait_results("rsvd", 2);
        expect_next("rsvd_110", 32'h0000_0000);
        expect_next("rsvd_111", 32'h0000_0000);

        // Reset with two beats in flight.
        load_config(3'b001);
        send(32'h3F80_0000, 32'h4000_0000, 32'h0);
        send(32'h3F80_0000, 32'h4000_0000, 32'h0);
        reset = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_out_data", out_data, 32'h0);
        repeat (2) tick();
        reset = 1'b0;
        repeat (6) tick();
        check("mid_rst_no_output", 32'(rq.size()), 32'd0);
        rq.delete();

        // After reset the op is ADD again and the weights are zero.
        send(32'h3F80_0000, 32'h4000_0000, 32'h0);
        wait_results("post_rst_add", 1);
        expect_next("post_rst_add", 32'h4040_0000);
        load_config(3'b011);
        send(32'h3F80_0000, 32'h0, 32'h0);
        wait_results("post_rst_sys", 1);
        expect_next("post_rst_sys", 32'h0000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
